// File: rtl/wieg_aandrijving_if.sv
// Request/status bus of the cradle driver: amplitude, frequency and fault in,
// step/direction stream and position status out.
interface wieg_aandrijving_if;
  logic [2:0]        A;
  logic [2:0]        F;
  logic              error;
  logic              stap;
  logic              richting;
  logic signed [7:0] positie;
  logic              midden;
  logic              actief;

  modport master (
    output A, F, error,
    input  stap, richting, positie, midden, actief
  );

  modport slave (
    input  A, F, error,
    output stap, richting, positie, midden, actief
  );
endinterface

// File: rtl/wieg_aandrijving.sv
// wieg_aandrijving -- step/direction driver producing a symmetric cradle swing about centre.
// Defining WIEG_SOFTSTART_EN makes F ramp up by one unit per centre crossing after a start.
module wieg_aandrijving #(
  parameter int CLK_DIV  = 1000,
  parameter int AMP_STAP = 4
) (
  input logic               clk,
  input logic               reset,
  wieg_aandrijving_if.slave bus
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    AMP_MUL  = 8'(AMP_STAP);

  typedef enum logic [2:0] {
    RUST  = 3'd0,
    HEEN  = 3'd1,
    TERUG = 3'd2,
    THUIS = 3'd3,
    FOUT  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     pre_r, pre_s;
  logic [2:0]        tick_cnt_r, tick_cnt_s;
  logic [2:0]        a_act_r, a_act_s;
  logic [2:0]        f_act_r, f_act_s;
  logic signed [7:0] pos_r, pos_s;
  logic              dir_r, dir_s;
  logic              stap_r, stap_s;
  logic              midden_r, actief_r;
  logic              tick_s, due_s, swing_s, crossing_s;
  logic              start_s, relatch_s, stop_s;
  logic [7:0]        amp_s, amp_neg_s;
  logic [2:0]        f_start_s, f_relatch_s;

  assign tick_s     = (pre_r == PRE_LAST);
  // The interval is 8-F_act ticks, so the last tick index is 7-F_act.
  assign due_s      = tick_s && (tick_cnt_r == (3'd7 - f_act_r));
  assign amp_s      = {5'd0, a_act_r} * AMP_MUL;
  assign amp_neg_s  = 8'd0 - amp_s;
  assign swing_s    = (state_r == HEEN) || (state_r == TERUG);
  assign crossing_s = swing_s && stap_s && (pos_s == 8'sd0);
  assign start_s    = (state_r == RUST) && (state_s == HEEN);
  assign relatch_s  = crossing_s && !bus.error;

`ifdef WIEG_SOFTSTART_EN
  assign f_start_s   = 3'd1;
  assign f_relatch_s = (bus.F > f_act_r) ? (f_act_r + 3'd1) : bus.F;
`else
  assign f_start_s   = bus.F;
  assign f_relatch_s = bus.F;
`endif

  assign stop_s = (bus.A == 3'd0) || (f_relatch_s == 3'd0);

  // Step generation: whether this edge steps, in which direction, and the resulting position.
  always_comb begin
    stap_s = 1'b0;
    dir_s  = dir_r;
    pos_s  = pos_r;
    case (state_r)
      HEEN: begin
        if (due_s) begin
          stap_s = 1'b1;
          dir_s  = 1'b1;
          pos_s  = pos_r + 8'sd1;
        end else begin
          stap_s = 1'b0;
        end
      end
      TERUG: begin
        if (due_s) begin
          stap_s = 1'b1;
          dir_s  = 1'b0;
          pos_s  = pos_r - 8'sd1;
        end else begin
          stap_s = 1'b0;
        end
      end
      THUIS: begin
        if (due_s && (pos_r != 8'sd0)) begin
          stap_s = 1'b1;
          dir_s  = pos_r[7];
          pos_s  = pos_r[7] ? (pos_r + 8'sd1) : (pos_r - 8'sd1);
        end else begin
          stap_s = 1'b0;
        end
      end
      RUST:    pos_s = 8'sd0;
      FOUT:    pos_s = 8'sd0;
      default: pos_s = 8'sd0;
    endcase
  end

  // Next-state logic; a fault outranks the centre-crossing relatch.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUST: begin
        if (bus.error) begin
          state_s = FOUT;
        end else if ((bus.A != 3'd0) && (bus.F != 3'd0)) begin
          state_s = HEEN;
        end else begin
          state_s = RUST;
        end
      end
      HEEN: begin
        if (bus.error) begin
          state_s = (pos_s == 8'sd0) ? FOUT : THUIS;
        end else if (crossing_s) begin
          state_s = stop_s ? RUST : HEEN;
        end else if (stap_s && ($unsigned(pos_s) == amp_s)) begin
          state_s = TERUG;
        end else begin
          state_s = HEEN;
        end
      end
      TERUG: begin
        if (bus.error) begin
          state_s = (pos_s == 8'sd0) ? FOUT : THUIS;
        end else if (crossing_s) begin
          state_s = stop_s ? RUST : TERUG;
        end else if (stap_s && ($unsigned(pos_s) == amp_neg_s)) begin
          state_s = HEEN;
        end else begin
          state_s = TERUG;
        end
      end
      THUIS: begin
        if (pos_s == 8'sd0) begin
          state_s = FOUT;
        end else begin
          state_s = THUIS;
        end
      end
      FOUT: begin
        if (!bus.error) begin
          state_s = RUST;
        end else begin
          state_s = FOUT;
        end
      end
      default: state_s = RUST;
    endcase
  end

  // Latches and counters; the prescaler keeps its phase across crossings.
  always_comb begin
    a_act_s    = a_act_r;
    f_act_s    = f_act_r;
    pre_s      = tick_s ? {PW{1'b0}} : (pre_r + PW'(1));
    tick_cnt_s = tick_cnt_r;
    if (start_s) begin
      a_act_s    = bus.A;
      f_act_s    = f_start_s;
      pre_s      = {PW{1'b0}};
      tick_cnt_s = 3'd0;
    end else if (relatch_s) begin
      a_act_s    = bus.A;
      f_act_s    = f_relatch_s;
      tick_cnt_s = 3'd0;
    end else if (!swing_s && (state_r != THUIS)) begin
      tick_cnt_s = 3'd0;
    end else if (due_s) begin
      tick_cnt_s = 3'd0;
    end else if (tick_s) begin
      tick_cnt_s = tick_cnt_r + 3'd1;
    end else begin
      tick_cnt_s = tick_cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUST;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r      <= {PW{1'b0}};
      tick_cnt_r <= 3'd0;
      a_act_r    <= 3'd0;
      f_act_r    <= 3'd0;
      pos_r      <= 8'sd0;
      dir_r      <= 1'b0;
      stap_r     <= 1'b0;
      midden_r   <= 1'b1;
      actief_r   <= 1'b0;
    end else begin
      pre_r      <= pre_s;
      tick_cnt_r <= tick_cnt_s;
      a_act_r    <= a_act_s;
      f_act_r    <= f_act_s;
      pos_r      <= pos_s;
      dir_r      <= dir_s;
      stap_r     <= stap_s;
      midden_r   <= (pos_s == 8'sd0);
      actief_r   <= (state_s == HEEN) || (state_s == TERUG) || (state_s == THUIS);
    end
  end

  assign bus.stap     = stap_r;
  assign bus.richting = dir_r;
  assign bus.positie  = pos_r;
  assign bus.midden   = midden_r;
  assign bus.actief   = actief_r;

endmodule

// File: tb/tb_wieg_aandrijving.sv
// Bench for wieg_aandrijving: scripted segment table, hand-written corner sequences and
// random stimulus, every cycle compared with a timestamp-based reference model.
`timescale 1ns/1ps
module tb_wieg_aandrijving;
  localparam int CD = 4;
  localparam int AS = 2;

  logic clk;
  logic reset;
  wieg_aandrijving_if bus ();

  wieg_aandrijving #(.CLK_DIV(CD), .AMP_STAP(AS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  // Reference model: mode 0 rest, 1 swing, 2 homing, 3 fault. Steps are scheduled as
  // absolute edge numbers: every step is (8-f)*CD edges after the previous one.
  int m_mode = 0;
  int m_pos  = 0;
  int m_a    = 0;
  int m_f    = 0;
  int m_next = 0;
  int cyc    = 0;
  bit m_up   = 1'b1;
  bit m_stap = 1'b0;
  bit m_dir  = 1'b0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] f;
    logic       err;
    int         n;
    int         pos;
    logic       act;
    logic       stp;
    logic       dir;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (shown < 60) begin
        shown++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
    end
  endtask

  function automatic int start_f(input int f_in);
`ifdef WIEG_SOFTSTART_EN
    return 1;
`else
    return f_in;
`endif
  endfunction

  function automatic int cross_f(input int f_in, input int f_cur);
`ifdef WIEG_SOFTSTART_EN
    return (f_in > f_cur) ? f_cur + 1 : f_in;
`else
    return f_in;
`endif
  endfunction

  task automatic model_edge();
    int a_in;
    int f_in;
    bit err;
    a_in   = int'(bus.A);
    f_in   = int'(bus.F);
    err    = bus.error;
    m_stap = 1'b0;
    if (reset) begin
      m_mode = 0; m_pos = 0; m_a = 0; m_f = 0; m_dir = 1'b0; m_up = 1'b1;
    end else begin
      case (m_mode)
        0: begin
          if (err) m_mode = 3;
          else if (a_in != 0 && f_in != 0) begin
            m_a = a_in; m_f = start_f(f_in); m_up = 1'b1;
            m_next = cyc + (8 - m_f) * CD; m_mode = 1;
          end
        end
        1: begin
          if (cyc == m_next) begin
            m_pos  = m_pos + (m_up ? 1 : -1);
            m_stap = 1'b1; m_dir = m_up;
            m_next = cyc + (8 - m_f) * CD;
            if (err) m_mode = (m_pos == 0) ? 3 : 2;
            else if (m_pos == 0) begin
              m_a = a_in; m_f = cross_f(f_in, m_f);
              if (m_a == 0 || m_f == 0) m_mode = 0;
              else m_next = cyc + (8 - m_f) * CD;
            end
            else if (m_pos == m_a * AS) m_up = 1'b0;
            else if (m_pos == -m_a * AS) m_up = 1'b1;
          end else if (err) begin
            m_mode = (m_pos == 0) ? 3 : 2;
          end
        end
        2: begin
          if (m_pos == 0) m_mode = 3;
          else if (cyc == m_next) begin
            m_stap = 1'b1; m_dir = (m_pos < 0);
            m_pos  = m_pos + ((m_pos < 0) ? 1 : -1);
            m_next = cyc + (8 - m_f) * CD;
            if (m_pos == 0) m_mode = 3;
          end
        end
        default: begin
          if (!err) m_mode = 0;
        end
      endcase
    end
    cyc++;
  endtask

  task automatic model_check();
    logic [11:0] got;
    logic [11:0] want;
    logic [7:0]  mp;
    mp   = 8'(m_pos);
    got  = {bus.stap, bus.richting, bus.positie, bus.midden, bus.actief};
    want = {m_stap, m_dir, mp, (m_pos == 0), (m_mode == 1 || m_mode == 2)};
    check("model", int'(got), int'(want));
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int last;
    int cnt;
    int j;

    // segment: inputs, edges to run, expected pos/actief/stap/richting after the last edge
    tbl[0]  = '{3'd1, 3'd7, 1'b0, 33,  0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{3'd1, 3'd7, 1'b0,  8,  2, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{3'd3, 3'd7, 1'b0,  8,  0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{3'd3, 3'd7, 1'b0, 24, -6, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{3'd3, 3'd7, 1'b0, 20, -1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{3'd3, 3'd0, 1'b0,  4,  0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{3'd3, 3'd0, 1'b0, 12,  0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{3'd1, 3'd7, 1'b0,  9,  2, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{3'd1, 3'd7, 1'b1,  9,  0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 3'd7, 1'b1,  8,  0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3'd1, 3'd7, 1'b0,  1,  0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'd1, 3'd7, 1'b0,  1,  0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3'd1, 3'd7, 1'b0,  3,  0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{3'd1, 3'd7, 1'b0,  1,  1, 1'b1, 1'b1, 1'b1};

    reset     = 1'b1;
    bus.A     = 3'd3;
    bus.F     = 3'd5;
    bus.error = 1'b0;

    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      check("rst_pos",    int'(bus.positie), 0);
      check("rst_midden", int'(bus.midden),  1);
      check("rst_actief", int'(bus.actief),  0);
      check("rst_stap",   int'(bus.stap),    0);
    end
    bus.A = 3'd0;
    bus.F = 3'd0;
    reset = 1'b0;
    repeat (2) clk_cycle();

`ifdef WIEG_SOFTSTART_EN
    bus.A = 3'd1;
    bus.F = 3'd7;
    clk_cycle();
    last = 0; cnt = 0; j = 0;
    while (j < 28 && cnt < 600) begin
      clk_cycle();
      cnt++;
      if (bus.stap) begin
        check("soft_gap", cnt - last, 28 - 4 * (((j / 4) < 6) ? (j / 4) : 6));
        last = cnt;
        j++;
      end
    end
    check("soft_steps", j, 28);
`else
    for (int r = 0; r < 14; r++) begin
      bus.A     = tbl[r].a;
      bus.F     = tbl[r].f;
      bus.error = tbl[r].err;
      for (int k = 0; k < tbl[r].n; k++) clk_cycle();
      check($sformatf("seg%0d_pos", r),    int'(bus.positie),  tbl[r].pos);
      check($sformatf("seg%0d_actief", r), int'(bus.actief),   int'(tbl[r].act));
      check($sformatf("seg%0d_stap", r),   int'(bus.stap),     int'(tbl[r].stp));
      check($sformatf("seg%0d_dir", r),    int'(bus.richting), int'(tbl[r].dir));
      check($sformatf("seg%0d_midden", r), int'(bus.midden),   (tbl[r].pos == 0) ? 1 : 0);
    end
`endif

    // Basic swing from rest: a step every 4 clocks with the required pattern.
    bus.error = 1'b0;
    bus.A     = 3'd0;
    bus.F     = 3'd0;
    reset     = 1'b1;
    clk_cycle();
    reset     = 1'b0;
    bus.A     = 3'd1;
    bus.F     = 3'd7;
`ifndef WIEG_SOFTSTART_EN
    begin
      int exp_pos[8];
      int exp_dir[8];
      exp_pos = '{1, 2, 1, 0, -1, -2, -1, 0};
      exp_dir = '{1, 1, 0, 0, 0, 0, 1, 1};
      clk_cycle();
      for (int k = 1; k <= 32; k++) begin
        clk_cycle();
        check("swing_stap", int'(bus.stap), (k % 4 == 0) ? 1 : 0);
        if (k % 4 == 0) begin
          check("swing_pos", int'(bus.positie),  exp_pos[k / 4 - 1]);
          check("swing_dir", int'(bus.richting), exp_dir[k / 4 - 1]);
        end
      end
    end
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        bus.A = 3'($urandom_range(0, 7));
        bus.F = 3'($urandom_range(0, 7));
      end
      if (bus.error) begin
        if ($urandom_range(0, 19) == 0) bus.error = 1'b0;
      end else begin
        if ($urandom_range(0, 299) == 0) bus.error = 1'b1;
      end
      reset = ($urandom_range(0, 1499) == 0);
      clk_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
